// File: rtl/spi_master_cmd.sv
// rtl/spi_master_cmd.sv - SPI mode-0 master issuing one 48-bit MRAM access frame per request
//
// Ports:
//   FPGA_clk  in   system clock (only clock)
//   FPGA_rst  in   asynchronous active-low reset
//   start     in   request strobe, honoured only in IDLE
//   rw        in   1 = read, 0 = write (latched with start)
//   addr      in   20-bit MRAM word address (latched with start)
//   wr_data   in   16-bit write data (latched with start)
//   busy      out  high from the cycle after acceptance to the end of the CS gap
//   done      out  one-cycle pulse as SSEL rises at frame end
//   rd_data   out  last read result, updated only by read frames
//   SCLK      out  SPI clock, idles low
//   SSEL      out  slave select, active-low
//   MOSI      out  serial data to slave, MSB first
//   MISO      in   serial data from slave
module spi_master_cmd #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        FPGA_clk,
  input  logic        FPGA_rst,
  input  logic        start,
  input  logic        rw,
  input  logic [19:0] addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SCLK,
  output logic        SSEL,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    edge_q, edge_d;
  logic [47:0]   shift_q, shift_d;
  logic [15:0]   rx_q, rx_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rw_q, rw_d;
  logic          sclk_q, sclk_d;
  logic          ssel_q, ssel_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [47:0]   frame;

  always_comb begin
    frame = {(rw ? 8'h03 : 8'h02), 4'b0000, addr, (rw ? 16'h0000 : wr_data)};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    edge_d    = edge_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    rw_d      = rw_q;
    sclk_d    = sclk_q;
    ssel_d    = ssel_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          rw_d    = rw;
          shift_d = frame;
          mosi_d  = frame[47];
          ssel_d  = 1'b0;
          busy_d  = 1'b1;
          edge_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // First rising edge; MISO bit 0 of 48 is a command-phase bit and is discarded.
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          edge_d  = 6'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            // edge_q holds the number of rising edges so far; the fall after the
            // 48th ends the frame without shifting MOSI.
            if (edge_q == 6'd48) begin
              state_d = HOLD;
            end else begin
              shift_d = {shift_q[46:0], 1'b0};
              mosi_d  = shift_q[46];
            end
          end else begin
            sclk_d = 1'b1;
            edge_d = edge_q + 6'd1;
            // Rising edges 33..48 are the data phase.
            if (edge_q >= 6'd32) begin
              rx_d = {rx_q[14:0], MISO};
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = GAP;
          if (rw_q) begin
            rd_data_d = rx_q;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
    if (!FPGA_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      rw_q      <= 1'b0;
      sclk_q    <= 1'b0;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      rw_q      <= rw_d;
      sclk_q    <= sclk_d;
      ssel_q    <= ssel_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign SCLK    = sclk_q;
  assign SSEL    = ssel_q;
  assign MOSI    = mosi_q;

endmodule
